// File: rtl/scene_loader.sv
// Background redraw engine: on a rising transition edge, stream one full scene from ROM to the VGA plot port.
// Latency: first plot 2 cycles after the start edge, then one pixel per cycle; done 1 cycle after the last plot.
// Backpressure: none; the VGA adapter accepts a pixel every cycle. A new start edge aborts and restarts the frame.
module scene_loader #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                transition,
  input  logic [3:0]          location,
  input  logic [3:0]          activity,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]        X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0]        Y_LAST = 7'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BASE_1 = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] BASE_2 = ADDR_W'(2 * WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_W  = ADDR_W'(WIDTH);

  // activity is part of the navigation bundle but does not affect the background
  logic unused_activity;
  assign unused_activity = ^activity;

  logic [1:0]        state_q, state_d;
  logic              trans_q;
  // armed_q: transition has been seen low since reset, so a level held
  // high across reset release is not mistaken for a fresh edge
  logic              armed_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fill_q, fill_d;
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // pixel pipeline stage: coordinates of the address issued last cycle
  logic              pv_q, pv_d;
  logic [7:0]        px_q, px_d;
  logic [6:0]        py_q, py_d;

  logic              start;
  logic              last_px;
  logic [ADDR_W-1:0] new_base;
  logic              new_fill;

  // Decode the scene base for the requested location; unknown codes fill black
  always_comb begin
    new_base = '0;
    new_fill = 1'b0;
    case (location)
      4'h0:    new_base = '0;
      4'h1:    new_base = BASE_1;
      4'h2:    new_base = BASE_2;
      default: new_fill = 1'b1;
    endcase
  end

  // Next-state logic: edge-triggered start, raster scan, one-cycle flush, done pulse
  always_comb begin
    start   = transition && !trans_q && armed_q;
    last_px = (cx_q == X_LAST) && (cy_q == Y_LAST);

    state_d = state_q;
    base_d  = base_q;
    fill_d  = fill_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    pv_d    = 1'b0;
    px_d    = px_q;
    py_d    = py_q;

    if (start) begin
      // Start (or restart): drop whatever is in the pipe and scan from (0,0)
      state_d = S_SCAN;
      base_d  = new_base;
      fill_d  = new_fill;
      cx_d    = '0;
      cy_d    = '0;
      addr_d  = new_base;
    end else begin
      case (state_q)
        S_SCAN: begin
          pv_d = 1'b1;
          px_d = cx_q;
          py_d = cy_q;
          if (last_px) begin
            state_d = S_FLUSH;
          end else begin
            if (cx_q == X_LAST) begin
              cx_d = '0;
              cy_d = cy_q + 7'd1;
            end else begin
              cx_d = cx_q + 8'd1;
            end
            addr_d = base_q + ADDR_W'(cy_d) * ROW_W + ADDR_W'(cx_d);
          end
        end
        S_FLUSH: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and pipeline registers; reset abandons any frame in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      trans_q <= 1'b0;
      armed_q <= 1'b0;
      base_q  <= '0;
      fill_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      trans_q <= transition;
      armed_q <= armed_q | ~transition;
      base_q  <= base_d;
      fill_q  <= fill_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      pv_q    <= pv_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign rom_addr = addr_q;
  assign x        = px_q;
  assign y        = py_q;
  assign plot     = pv_q;
  assign colour   = (pv_q && !fill_q) ? rom_data : '0;
  assign busy     = (state_q == S_SCAN) || (state_q == S_FLUSH);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_scene_loader.sv
// Self-checking bench for scene_loader: vector table for reset/start, scoreboard for every plotted pixel.
// Latency checked explicitly around start, restart and reset; full frames checked pixel by pixel.
// No backpressure on the DUT; every wait is bounded by a cycle budget.
module tb_scene_loader;

  logic        clk;
  logic        reset;
  logic        transition;
  logic [3:0]  location;
  logic [3:0]  activity;
  logic [15:0] rom_addr;
  logic [2:0]  rom_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  scene_loader dut (
    .clk        (clk),
    .reset      (reset),
    .transition (transition),
    .location   (location),
    .activity   (activity),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle read latency, data = low address bits
  always @(posedge clk) rom_data <= rom_addr[2:0];

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  col;
    logic [15:0] addr;
  } px_t;

  px_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int last_plot_cyc = 0;
  int done_cyc = 0;
  int last_x = 0;
  int last_y = 0;
  logic [15:0] last_addr = '0;
  logic        prev_busy = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected pixels of one frame for a location code
  task automatic push_frame(input logic [3:0] loc);
    int  base;
    bit  fill;
    px_t p;
    base = (loc == 4'h1) ? 19200 : (loc == 4'h2) ? 38400 : 0;
    fill = (loc > 4'h2);
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        p.x    = 8'(xx);
        p.y    = 7'(yy);
        p.addr = 16'(base + yy * 160 + xx);
        p.col  = fill ? 3'd0 : p.addr[2:0];
        sb.push_back(p);
      end
    end
  endtask

  // Output monitor: scoreboard pops on every plot, address checked against the one issued a cycle earlier
  initial begin
    px_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (plot === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pixel: unexpected plot at x=%0d y=%0d", x, y);
        end else begin
          e = sb.pop_front();
          if (x !== e.x || y !== e.y || colour !== e.col || last_addr !== e.addr) begin
            n_fail++;
            $display("FAIL pixel: got x=%0d y=%0d col=%0d addr=%0d, expected x=%0d y=%0d col=%0d addr=%0d",
                     x, y, colour, last_addr, e.x, e.y, e.col, e.addr);
          end
        end
        plot_cnt++;
        last_plot_cyc = cyc;
        last_x = int'(x);
        last_y = int'(y);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_at_done", int'(busy), 0);
        chk("busy_high_before_done", int'(prev_busy), 1);
      end
      prev_busy = busy;
      last_addr = rom_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n;
    n = 0;
    while (done_cnt < target && n < 25000) begin
      step();
      n++;
    end
    if (done_cnt < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic wait_plots(input int target, input string nm);
    int n;
    n = 0;
    while (plot_cnt < target && n < 25000) begin
      step();
      n++;
    end
    if (plot_cnt < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: plot count stuck at %0d", nm, plot_cnt);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        tr;
    logic [3:0]  loc;
    logic        e_plot;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_addr;
    logic [7:0]  e_x;
    logic [2:0]  e_col;
  } vec_t;

  vec_t tv[9];

  initial begin
    int p0;
    int d0;

    // Reset held with transition high, release with it still high, then a real 0->1 edge for HOME
    tv[0] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'd0,     8'd0, 3'd0};
    tv[1] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'd0,     8'd0, 3'd0};
    tv[2] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'd0,     8'd0, 3'd0};
    tv[3] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'd0,     8'd0, 3'd0};
    tv[4] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'd0,     8'd0, 3'd0};
    tv[5] = '{1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 16'd0,     8'd0, 3'd0};
    tv[6] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'd19200, 8'd0, 3'd0};
    tv[7] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 16'd19201, 8'd0, 3'd0};
    tv[8] = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 16'd19202, 8'd1, 3'd1};

    reset      = 1'b1;
    transition = 1'b1;
    location   = 4'h1;
    activity   = 4'h0;

    // ---- reset + HOME start, table driven ----
    push_frame(4'h1);
    for (int i = 0; i < 9; i++) begin
      reset      = tv[i].rst;
      transition = tv[i].tr;
      location   = tv[i].loc;
      step();
      chk($sformatf("vec%0d_plot", i), int'(plot), int'(tv[i].e_plot));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tv[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tv[i].e_done));
      chk($sformatf("vec%0d_addr", i), int'(rom_addr), int'(tv[i].e_addr));
      chk($sformatf("vec%0d_x", i), int'(x), int'(tv[i].e_x));
      chk($sformatf("vec%0d_col", i), int'(colour), int'(tv[i].e_col));
    end

    // ---- HOME frame completes ----
    location = 4'h5;  // changing location without an edge must be ignored
    wait_done(1, "home_done");
    step();
    chk("home_plots", plot_cnt, 19200);
    chk("home_done_count", done_cnt, 1);
    chk("home_last_x", last_x, 159);
    chk("home_last_y", last_y, 119);
    chk("home_done_after_last", done_cyc - last_plot_cyc, 1);
    chk("home_sb_empty", sb.size(), 0);

    // ---- unknown location fills black ----
    p0 = plot_cnt;
    d0 = done_cnt;
    transition = 1'b0;
    step();
    push_frame(4'h7);
    transition = 1'b1;
    location   = 4'h7;
    step();
    chk("fill_busy", int'(busy), 1);
    chk("fill_first_addr", int'(rom_addr), 0);
    wait_done(d0 + 1, "fill_done");
    step();
    chk("fill_plots", plot_cnt - p0, 19200);
    chk("fill_done_count", done_cnt - d0, 1);
    chk("fill_sb_empty", sb.size(), 0);

    // ---- restart: HOME aborted at plot 500, ARCADE restarts ----
    p0 = plot_cnt;
    d0 = done_cnt;
    transition = 1'b0;
    step();
    push_frame(4'h1);
    transition = 1'b1;
    location   = 4'h1;
    step();
    wait_plots(p0 + 500, "restart_reach_500");
    transition = 1'b0;
    step();
    transition = 1'b1;
    location   = 4'h2;
    step();
    sb.delete();
    push_frame(4'h2);
    chk("restart_plot_gap", int'(plot), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_first_addr", int'(rom_addr), 38400);
    p0 = plot_cnt;
    step();
    chk("restart_plot_resume", int'(plot), 1);
    chk("restart_x0", int'(x), 0);
    chk("restart_y0", int'(y), 0);
    wait_done(d0 + 1, "restart_done");
    step();
    step();
    chk("restart_plots", plot_cnt - p0, 19200);
    chk("restart_done_count", done_cnt - d0, 1);
    chk("arcade_last_addr", int'(last_addr), 57599);
    chk("restart_sb_empty", sb.size(), 0);

    // ---- reset mid-scan ----
    p0 = plot_cnt;
    d0 = done_cnt;
    transition = 1'b0;
    step();
    push_frame(4'h1);
    transition = 1'b1;
    location   = 4'h1;
    step();
    wait_plots(p0 + 1000, "rst_reach_1000");
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(rom_addr), 0);
    p0 = plot_cnt;
    for (int i = 0; i < 50; i++) step();
    chk("rst_idle_busy", int'(busy), 0);
    chk("rst_no_plots", plot_cnt - p0, 0);
    chk("rst_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
